// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, mstatus/mie bit positions, widths.
// Counter CSRs exist only when CSR_COUNTERS_EN is defined.
package csr_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int BUS_ADDR_WIDTH = 32;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIE_MSIE = 3;
    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    localparam logic [31:0] MIE_MASK =
        (32'd1 << MIE_MSIE) | (32'd1 << MIE_MTIE) | (32'd1 << MIE_MEIE);

    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

    function automatic logic [31:0] mstatus_pack(input mstatus_t s);
        logic [31:0] v;
        v = '0;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        v[MSTATUS_MPIE] = s.mpie;
        v[MSTATUS_MIE] = s.mie;
        return v;
    endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access bus between the execute-stage CSR unit (master)
// and the CSR register file (slave).
interface csr_if import csr_pkg::*; ();

    logic [31:0]               csr_raddr_i;
    logic [REG_DATA_WIDTH-1:0] csr_rdata_o;
    logic                      csr_illegal_o;
    logic                      csr_we_i;
    logic [BUS_ADDR_WIDTH-1:0] csr_waddr_i;
    logic [REG_DATA_WIDTH-1:0] csr_wdata_i;

    modport master (
        output csr_raddr_i,
        output csr_we_i,
        output csr_waddr_i,
        output csr_wdata_i,
        input  csr_rdata_o,
        input  csr_illegal_o
    );

    modport slave (
        input  csr_raddr_i,
        input  csr_we_i,
        input  csr_waddr_i,
        input  csr_wdata_i,
        output csr_rdata_o,
        output csr_illegal_o
    );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit performance counter with per-half software writes.
// A write to either half suppresses that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [63:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (we_lo) begin
            cnt[31:0] <= wdata;
        end else if (we_hi) begin
            cnt[63:32] <= wdata;
        end else if (inc && !inhibit) begin
            cnt <= cnt + 64'd1;
        end
    end

    assign lo = cnt[31:0];
    assign hi = cnt[63:32];

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file with trap/mret handling.
// Define CSR_COUNTERS_EN to build mcycle/minstret/mcountinhibit.
module csr_regfile import csr_pkg::*; #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_1104,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    csr_if.slave        bus,
    input  logic        trap_enter_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic        mret_i,
    input  logic        inst_retire_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        irq_sw_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mie_o,
    output logic        global_int_en_o
);

    logic [11:0] raddr;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        wr;

    mstatus_t    mstatus_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [31:0] mip;
    logic [31:0] rdata;
    logic        illegal;
    logic        unused_bits;

    assign raddr = bus.csr_raddr_i[11:0];
    assign waddr = bus.csr_waddr_i[11:0];
    assign wdata = bus.csr_wdata_i;

    // A trap swallows any CSR write issued in the same cycle.
    assign wr = bus.csr_we_i && !trap_enter_i;

    assign mip = {20'd0, irq_ext_i, 3'd0, irq_timer_i, 3'd0, irq_sw_i, 3'd0};

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_enter_i) begin
            mepc_q         <= {trap_pc_i[31:1], 1'b0};
            mcause_q       <= trap_cause_i;
            mstatus_q.mpie <= mstatus_q.mie;
            mstatus_q.mie  <= 1'b0;
        end else begin
            if (mret_i) begin
                mstatus_q.mie  <= mstatus_q.mpie;
                mstatus_q.mpie <= 1'b1;
            end else if (wr && waddr == CSR_MSTATUS) begin
                mstatus_q.mie  <= wdata[MSTATUS_MIE];
                mstatus_q.mpie <= wdata[MSTATUS_MPIE];
            end
            if (wr) begin
                case (waddr)
                    CSR_MIE:      mie_q      <= wdata & MIE_MASK;
                    CSR_MTVEC:    mtvec_q    <= {wdata[31:2], 2'b00};
                    CSR_MSCRATCH: mscratch_q <= wdata;
                    CSR_MEPC:     mepc_q     <= {wdata[31:1], 1'b0};
                    CSR_MCAUSE:   mcause_q   <= wdata;
                    CSR_MTVAL:    mtval_q    <= wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic        cy_q;
    logic        ir_q;
    logic [31:0] cyc_lo;
    logic [31:0] cyc_hi;
    logic [31:0] ret_lo;
    logic [31:0] ret_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            cy_q <= 1'b0;
            ir_q <= 1'b0;
        end else if (wr && waddr == CSR_MCOUNTINHIBIT) begin
            cy_q <= wdata[0];
            ir_q <= wdata[2];
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .inhibit (cy_q),
        .we_lo   (wr && waddr == CSR_MCYCLE),
        .we_hi   (wr && waddr == CSR_MCYCLEH),
        .wdata   (wdata),
        .lo      (cyc_lo),
        .hi      (cyc_hi)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc     (inst_retire_i),
        .inhibit (ir_q),
        .we_lo   (wr && waddr == CSR_MINSTRET),
        .we_hi   (wr && waddr == CSR_MINSTRETH),
        .wdata   (wdata),
        .lo      (ret_lo),
        .hi      (ret_hi)
    );

    assign unused_bits = ^{bus.csr_raddr_i[31:12], bus.csr_waddr_i[31:12]};
`else
    assign unused_bits = ^{bus.csr_raddr_i[31:12], bus.csr_waddr_i[31:12],
                           inst_retire_i};
`endif

    // Reads see pre-edge state; same-cycle writes are not bypassed.
    always_comb begin
        rdata   = '0;
        illegal = 1'b0;
        unique case (raddr)
            CSR_MSTATUS:  rdata = mstatus_pack(mstatus_q);
            CSR_MISA:     rdata = MISA_VAL;
            CSR_MIE:      rdata = mie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MTVAL:    rdata = mtval_q;
            CSR_MIP:      rdata = mip;
            CSR_MHARTID:  rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCOUNTINHIBIT: rdata = {29'd0, ir_q, 1'b0, cy_q};
            CSR_MCYCLE:        rdata = cyc_lo;
            CSR_MCYCLEH:       rdata = cyc_hi;
            CSR_MINSTRET:      rdata = ret_lo;
            CSR_MINSTRETH:     rdata = ret_hi;
`else
            CSR_MCOUNTINHIBIT,
            CSR_MCYCLE,
            CSR_MCYCLEH,
            CSR_MINSTRET,
            CSR_MINSTRETH:     rdata = '0;
`endif
            default: illegal = 1'b1;
        endcase
    end

    assign bus.csr_rdata_o   = rdata;
    assign bus.csr_illegal_o = illegal;

    assign mtvec_o         = mtvec_q;
    assign mepc_o          = mepc_q;
    assign mie_o           = mie_q;
    assign global_int_en_o = mstatus_q.mie;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios plus
// randomized traffic against a behavioural CSR model.
module tb_csr_regfile;
    import csr_pkg::*;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0000;
`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_enter, mret, retire;
    logic        irq_ext, irq_timer, irq_sw;
    logic [31:0] trap_pc, trap_cause;
    logic [31:0] mtvec_o, mepc_o, mie_o;
    logic        gie_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_if bus();

    csr_regfile #(
        .MTVEC_RESET (MTVEC_RST),
        .MISA_VAL    (32'h4000_1104),
        .HART_ID     (32'd0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .trap_enter_i    (trap_enter),
        .trap_pc_i       (trap_pc),
        .trap_cause_i    (trap_cause),
        .mret_i          (mret),
        .inst_retire_i   (retire),
        .irq_ext_i       (irq_ext),
        .irq_timer_i     (irq_timer),
        .irq_sw_i        (irq_sw),
        .mtvec_o         (mtvec_o),
        .mepc_o          (mepc_o),
        .mie_o           (mie_o),
        .global_int_en_o (gie_o)
    );

    // Behavioural model state
    bit          m_gie, m_mpie, m_cy, m_ir;
    logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ret;

    function automatic logic [32:0] exp_read(input logic [31:0] a);
        logic [31:0] d;
        bit          ill;
        d   = 32'd0;
        ill = 1'b0;
        case (a[11:0])
            12'h300: d = 32'h1800 | (32'(m_gie) << 3) | (32'(m_mpie) << 7);
            12'h301: d = 32'h4000_1104;
            12'h304: d = m_mie;
            12'h305: d = m_mtvec;
            12'h340: d = m_mscratch;
            12'h341: d = m_mepc;
            12'h342: d = m_mcause;
            12'h343: d = m_mtval;
            12'h344: d = (32'(irq_ext) << 11) | (32'(irq_timer) << 7)
                         | (32'(irq_sw) << 3);
            12'hF14: d = 32'd0;
            12'h320: d = CNT_EN ? (32'(m_ir) << 2) | 32'(m_cy) : 32'd0;
            12'hB00: d = CNT_EN ? m_cyc[31:0]  : 32'd0;
            12'hB80: d = CNT_EN ? m_cyc[63:32] : 32'd0;
            12'hB02: d = CNT_EN ? m_ret[31:0]  : 32'd0;
            12'hB82: d = CNT_EN ? m_ret[63:32] : 32'd0;
            default: ill = 1'b1;
        endcase
        return {ill, d};
    endfunction

    task automatic model_step();
        bit          wr, old_gie, old_mpie, old_cy, old_ir;
        logic [11:0] a;
        logic [31:0] wd;
        if (rst) begin
            m_gie = 0; m_mpie = 0; m_cy = 0; m_ir = 0;
            m_mie = 0; m_mtvec = MTVEC_RST & ~32'd3; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_cyc = 0; m_ret = 0;
            return;
        end
        wr       = bus.csr_we_i && !trap_enter;
        a        = bus.csr_waddr_i[11:0];
        wd       = bus.csr_wdata_i;
        old_gie  = m_gie;
        old_mpie = m_mpie;
        old_cy   = m_cy;
        old_ir   = m_ir;
        if (CNT_EN) begin
            if (wr && a == 12'hB00)      m_cyc[31:0]  = wd;
            else if (wr && a == 12'hB80) m_cyc[63:32] = wd;
            else if (!old_cy)            m_cyc        = m_cyc + 64'd1;
            if (wr && a == 12'hB02)      m_ret[31:0]  = wd;
            else if (wr && a == 12'hB82) m_ret[63:32] = wd;
            else if (retire && !old_ir)  m_ret        = m_ret + 64'd1;
        end
        if (trap_enter) begin
            m_mepc   = trap_pc & ~32'd1;
            m_mcause = trap_cause;
            m_mpie   = old_gie;
            m_gie    = 1'b0;
        end else begin
            if (mret) begin
                m_gie  = old_mpie;
                m_mpie = 1'b1;
            end
            if (wr) begin
                case (a)
                    12'h300: if (!mret) begin m_gie = wd[3]; m_mpie = wd[7]; end
                    12'h304: m_mie      = wd & 32'h0000_0888;
                    12'h305: m_mtvec    = wd & ~32'd3;
                    12'h340: m_mscratch = wd;
                    12'h341: m_mepc     = wd & ~32'd1;
                    12'h342: m_mcause   = wd;
                    12'h343: m_mtval    = wd;
                    12'h320: if (CNT_EN) begin m_cy = wd[0]; m_ir = wd[2]; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic idle();
        bus.csr_we_i    = 1'b0;
        bus.csr_waddr_i = 32'd0;
        bus.csr_wdata_i = 32'd0;
        trap_enter      = 1'b0;
        trap_pc         = 32'd0;
        trap_cause      = 32'd0;
        mret            = 1'b0;
        retire          = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        idle();
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = {20'd0, a};
        bus.csr_wdata_i = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        irq_ext = 0; irq_timer = 0; irq_sw = 0;
        bus.csr_raddr_i = 32'd0;
        idle();
        tick();
        tick();
        bus.csr_raddr_i = 32'h300; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'h0000_1800) begin
            n_err++;
            $display("FAIL reset_mstatus got=%h exp=%h", bus.csr_rdata_o, 32'h1800);
        end
        bus.csr_raddr_i = 32'h305; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== MTVEC_RST) begin
            n_err++;
            $display("FAIL reset_mtvec got=%h exp=%h", bus.csr_rdata_o, MTVEC_RST);
        end
        bus.csr_raddr_i = 32'h301; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'h4000_1104) begin
            n_err++;
            $display("FAIL reset_misa got=%h exp=%h", bus.csr_rdata_o, 32'h40001104);
        end
        n_cmp++;
        if (gie_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gie got=%b exp=0", gie_o);
        end
        rst = 1'b0;
        tick();
        bus.csr_raddr_i = 32'hB00; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== (CNT_EN ? 32'd1 : 32'd0)) begin
            n_err++;
            $display("FAIL first_mcycle got=%h exp=%h", bus.csr_rdata_o,
                     CNT_EN ? 32'd1 : 32'd0);
        end
    endtask

    task automatic test_mtvec();
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = 32'h305;
        bus.csr_wdata_i = 32'h8000_0103;
        bus.csr_raddr_i = 32'h305;
        #1;
        n_cmp++;
        if (bus.csr_rdata_o !== MTVEC_RST) begin
            n_err++;
            $display("FAIL mtvec_collision got=%h exp=%h", bus.csr_rdata_o, MTVEC_RST);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'h8000_0100) begin
            n_err++;
            $display("FAIL mtvec_write got=%h exp=%h", bus.csr_rdata_o, 32'h80000100);
        end
        n_cmp++;
        if (mtvec_o !== 32'h8000_0100) begin
            n_err++;
            $display("FAIL mtvec_out got=%h exp=%h", mtvec_o, 32'h80000100);
        end
    endtask

    task automatic test_trap_mret();
        wr_csr(12'h340, 32'h1234_5678);
        wr_csr(12'h300, 32'h0000_0008);
        n_cmp++;
        if (gie_o !== 1'b1) begin
            n_err++;
            $display("FAIL gie_set got=%b exp=1", gie_o);
        end
        trap_enter      = 1'b1;
        trap_pc         = 32'h8000_0042;
        trap_cause      = 32'h8000_000B;
        mret            = 1'b1;
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = 32'h340;
        bus.csr_wdata_i = 32'hDEAD_BEEF;
        tick();
        idle();
        n_cmp++;
        if (mepc_o !== 32'h8000_0042) begin
            n_err++;
            $display("FAIL trap_mepc got=%h exp=%h", mepc_o, 32'h80000042);
        end
        bus.csr_raddr_i = 32'h342; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'h8000_000B) begin
            n_err++;
            $display("FAIL trap_mcause got=%h exp=%h", bus.csr_rdata_o, 32'h8000000B);
        end
        bus.csr_raddr_i = 32'h300; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'h0000_1880) begin
            n_err++;
            $display("FAIL trap_mstatus got=%h exp=%h", bus.csr_rdata_o, 32'h1880);
        end
        bus.csr_raddr_i = 32'h340; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL trap_drop_write got=%h exp=%h", bus.csr_rdata_o, 32'h12345678);
        end
        mret = 1'b1;
        tick();
        idle();
        bus.csr_raddr_i = 32'h300; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'h0000_1888) begin
            n_err++;
            $display("FAIL mret_mstatus got=%h exp=%h", bus.csr_rdata_o, 32'h1888);
        end
        wr_csr(12'h300, 32'h0000_0000);
        mret            = 1'b1;
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = 32'h300;
        bus.csr_wdata_i = 32'h0000_0088;
        tick();
        idle();
        #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'h0000_1880) begin
            n_err++;
            $display("FAIL mret_beats_write got=%h exp=%h", bus.csr_rdata_o, 32'h1880);
        end
    endtask

    task automatic test_counters();
        if (CNT_EN) begin
            wr_csr(12'hB00, 32'hFFFF_FFFF);
            wr_csr(12'hB80, 32'h0000_0000);
            tick();
            bus.csr_raddr_i = 32'hB00; #1;
            n_cmp++;
            if (bus.csr_rdata_o !== 32'd0) begin
                n_err++;
                $display("FAIL carry_lo got=%h exp=0", bus.csr_rdata_o);
            end
            bus.csr_raddr_i = 32'hB80; #1;
            n_cmp++;
            if (bus.csr_rdata_o !== 32'd1) begin
                n_err++;
                $display("FAIL carry_hi got=%h exp=1", bus.csr_rdata_o);
            end
            wr_csr(12'hB00, 32'hFFFF_FFFE);
            tick();
            wr_csr(12'hB00, 32'h0000_0077);
            bus.csr_raddr_i = 32'hB00; #1;
            n_cmp++;
            if (bus.csr_rdata_o !== 32'h77) begin
                n_err++;
                $display("FAIL wr_beats_carry_lo got=%h exp=%h", bus.csr_rdata_o, 32'h77);
            end
            bus.csr_raddr_i = 32'hB80; #1;
            n_cmp++;
            if (bus.csr_rdata_o !== 32'd1) begin
                n_err++;
                $display("FAIL wr_beats_carry_hi got=%h exp=1", bus.csr_rdata_o);
            end
            wr_csr(12'h320, 32'h0000_0001);
            tick();
            tick();
            bus.csr_raddr_i = 32'hB00; #1;
            n_cmp++;
            if (bus.csr_rdata_o !== 32'h78) begin
                n_err++;
                $display("FAIL cy_hold got=%h exp=%h", bus.csr_rdata_o, 32'h78);
            end
            wr_csr(12'h320, 32'h0000_0000);
        end else begin
            wr_csr(12'hB00, 32'h0000_0055);
            bus.csr_raddr_i = 32'hB00; #1;
            n_cmp++;
            if (bus.csr_rdata_o !== 32'd0 || bus.csr_illegal_o !== 1'b0) begin
                n_err++;
                $display("FAIL cnt_off got=%h/%b exp=0/0",
                         bus.csr_rdata_o, bus.csr_illegal_o);
            end
        end
    endtask

    task automatic test_illegal();
        logic [11:0] probe [6] = '{12'h300, 12'h304, 12'h305,
                                   12'h340, 12'h343, 12'h7C0};
        bus.csr_raddr_i = 32'h7C0; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'd0 || bus.csr_illegal_o !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_read got=%h/%b exp=0/1",
                     bus.csr_rdata_o, bus.csr_illegal_o);
        end
        wr_csr(12'h7C0, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            logic [32:0] e;
            bus.csr_raddr_i = {20'd0, probe[i]}; #1;
            e = exp_read(bus.csr_raddr_i);
            n_cmp++;
            if ({bus.csr_illegal_o, bus.csr_rdata_o} !== e) begin
                n_err++;
                $display("FAIL illegal_write_%h got=%h exp=%h", probe[i],
                         {bus.csr_illegal_o, bus.csr_rdata_o}, e);
            end
        end
    endtask

    task automatic test_reset_midway();
        wr_csr(12'h340, 32'hA5A5_A5A5);
        wr_csr(12'h300, 32'h0000_0088);
        rst             = 1'b1;
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = 32'h305;
        bus.csr_wdata_i = 32'h1111_1110;
        trap_enter      = 1'b0;
        retire          = 1'b1;
        tick();
        idle();
        rst = 1'b0;
        bus.csr_raddr_i = 32'h340; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'd0) begin
            n_err++;
            $display("FAIL midreset_mscratch got=%h exp=0", bus.csr_rdata_o);
        end
        bus.csr_raddr_i = 32'h300; #1;
        n_cmp++;
        if (bus.csr_rdata_o !== 32'h1800) begin
            n_err++;
            $display("FAIL midreset_mstatus got=%h exp=%h", bus.csr_rdata_o, 32'h1800);
        end
        n_cmp++;
        if (mtvec_o !== MTVEC_RST) begin
            n_err++;
            $display("FAIL midreset_mtvec got=%h exp=%h", mtvec_o, MTVEC_RST);
        end
    endtask

    task automatic test_random();
        logic [11:0] addrs [16] = '{12'h300, 12'h301, 12'h304, 12'h305,
                                    12'h320, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'h344, 12'hB00, 12'hB80,
                                    12'hB02, 12'hB82, 12'hF14, 12'h7C0};
        for (int c = 0; c < 800; c++) begin
            logic [32:0] e;
            rst             = ($urandom_range(63) == 0);
            bus.csr_we_i    = $urandom_range(1);
            bus.csr_waddr_i = {$urandom_range(1) ? 20'h0 : 20'($urandom),
                               addrs[$urandom_range(15)]};
            bus.csr_wdata_i = $urandom;
            trap_enter      = ($urandom_range(9) == 0);
            trap_pc         = $urandom;
            trap_cause      = $urandom;
            mret            = ($urandom_range(7) == 0);
            retire          = $urandom_range(1);
            irq_ext         = $urandom_range(1);
            irq_timer       = $urandom_range(1);
            irq_sw          = $urandom_range(1);
            bus.csr_raddr_i = {20'($urandom), addrs[$urandom_range(15)]};
            #1;
            e = exp_read(bus.csr_raddr_i);
            n_cmp++;
            if ({bus.csr_illegal_o, bus.csr_rdata_o} !== e) begin
                n_err++;
                $display("FAIL rand_read c=%0d addr=%h got=%h exp=%h", c,
                         bus.csr_raddr_i, {bus.csr_illegal_o, bus.csr_rdata_o}, e);
            end
            n_cmp++;
            if ({mtvec_o, mepc_o, mie_o, gie_o} !==
                {m_mtvec, m_mepc, m_mie, m_gie}) begin
                n_err++;
                $display("FAIL rand_outs c=%0d got=%h %h %h %b exp=%h %h %h %b", c,
                         mtvec_o, mepc_o, mie_o, gie_o,
                         m_mtvec, m_mepc, m_mie, m_gie);
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_mtvec();
        test_trap_mret();
        test_counters();
        test_illegal();
        test_reset_midway();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
